// File: rtl/param_piso_serial_tx.sv
// Parallel-in/serial-out transmitter, MSB first, one bit per clk, with valid/last flags.
// Optional even-parity trailer bit when PARAM_PISO_PARITY_EN is defined.
module param_piso_serial_tx #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             last_bit
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] CNT_INIT = CW'(width - 1);

`ifdef PARAM_PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [width-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             load;
`ifdef PARAM_PISO_PARITY_EN
  logic             par;
`endif

  assign load_ready = (state == IDLE) && rst_n;
  assign load       = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef PARAM_PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load) begin
        sreg <= data_in;
        cnt  <= CNT_INIT;
`ifdef PARAM_PISO_PARITY_EN
        par  <= ^data_in;
`endif
      end else if (state == SHIFT) begin
        // Zero fill keeps the register clean once the frame has drained.
        sreg <= sreg << 1;
        cnt  <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    data_out  = 1'b0;
    bit_valid = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        data_out  = sreg[width-1];
        bit_valid = 1'b1;
        if (cnt == '0) begin
`ifdef PARAM_PISO_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = IDLE;
          last_bit  = 1'b1;
`endif
        end
      end
`ifdef PARAM_PISO_PARITY_EN
      PAR: begin
        data_out  = par;
        bit_valid = 1'b1;
        last_bit  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_param_piso_serial_tx.sv
// Bench for param_piso_serial_tx: width-8 and width-4 instances, scoreboarded serial output.
// Parity expectations follow PARAM_PISO_PARITY_EN.
module tb_param_piso_serial_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] data_in8;
  logic       load_valid8, load_ready8, data_out8, bit_valid8, last_bit8;
  logic [3:0] data_in4;
  logic       load_valid4, load_ready4, data_out4, bit_valid4, last_bit4;

  param_piso_serial_tx #(.width(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in8), .load_valid(load_valid8),
    .load_ready(load_ready8), .data_out(data_out8), .bit_valid(bit_valid8), .last_bit(last_bit8));

  param_piso_serial_tx #(.width(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in4), .load_valid(load_valid4),
    .load_ready(load_ready4), .data_out(data_out4), .bit_valid(bit_valid4), .last_bit(last_bit4));

`ifdef PARAM_PISO_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic       b;
    logic       last;
    logic       fin;
    logic [7:0] word;
  } exp_t;

  typedef struct {
    logic [7:0] word;
    logic       exp_par;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int w, input logic [7:0] word, input logic p);
    exp_t e;
    for (int i = 0; i < w; i++) begin
      e.b    = word[w-1-i];
      e.last = (i == w - 1) && !PAR_ON;
      e.fin  = (i == w - 1);
      e.word = word;
      if (w == 8) q8.push_back(e); else q4.push_back(e);
    end
    if (PAR_ON) begin
      e.b = p; e.last = 1'b1; e.fin = 1'b0; e.word = word;
      if (w == 8) q8.push_back(e); else q4.push_back(e);
    end
  endtask

  // Scoreboard monitors: model the downstream shift-left register too.
  logic [7:0] ds8;
  logic [3:0] ds4;
  always @(negedge clk) begin : mon8
    exp_t e;
    if (bit_valid8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bit8: got data_out=%b expected no bit at %0t", data_out8, $time);
      end else begin
        e = q8.pop_front();
        chk("bit8", {31'b0, data_out8}, {31'b0, e.b});
        chk("last8", {31'b0, last_bit8}, {31'b0, e.last});
        ds8 = {ds8[6:0], data_out8};
        if (e.fin) chk("word8", {24'b0, ds8}, {24'b0, e.word});
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (bit_valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bit4: got data_out=%b expected no bit at %0t", data_out4, $time);
      end else begin
        e = q4.pop_front();
        chk("bit4", {31'b0, data_out4}, {31'b0, e.b});
        chk("last4", {31'b0, last_bit4}, {31'b0, e.last});
        ds4 = {ds4[2:0], data_out4};
        if (e.fin) chk("word4", {28'b0, ds4}, {24'b0, e.word});
      end
    end
  end

  // Frame-shape checks for one instance; called right after the handshake edge.
  task automatic frame_shape(input int w);
    int fl;
    fl = w + (PAR_ON ? 1 : 0);
    for (int i = 0; i < fl; i++) begin
      @(negedge clk);
      if (w == 8) chk("frame_vld8", {30'b0, bit_valid8, load_ready8}, 32'h2);
      else        chk("frame_vld4", {30'b0, bit_valid4, load_ready4}, 32'h2);
    end
    @(negedge clk);
    if (w == 8) chk("frame_end8", {30'b0, bit_valid8, load_ready8}, 32'h1);
    else        chk("frame_end4", {30'b0, bit_valid4, load_ready4}, 32'h1);
  endtask

  task automatic send8(input logic [7:0] w, input logic p);
    int n = 0;
    while (load_ready8 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ready_timeout8", 32'h0, 32'h1);
    data_in8 = w; load_valid8 = 1'b1;
    push(8, w, p);
    @(posedge clk); #1;
    load_valid8 = 1'b0; data_in8 = 8'($urandom);
    frame_shape(8);
  endtask

  task automatic send4(input logic [3:0] w, input logic p);
    int n = 0;
    while (load_ready4 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ready_timeout4", 32'h0, 32'h1);
    data_in4 = w; load_valid4 = 1'b1;
    push(4, {4'b0, w}, p);
    @(posedge clk); #1;
    load_valid4 = 1'b0; data_in4 = 4'($urandom);
    frame_shape(4);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h81, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h3C, 1'b0};

    rst_n = 1'b0; load_valid8 = 1'b0; load_valid4 = 1'b0;
    data_in8 = 8'h00; data_in4 = 4'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_outs8", {28'b0, data_out8, bit_valid8, last_bit8, load_ready8}, 32'h0);
    chk("rst_outs4", {28'b0, data_out4, bit_valid4, last_bit4, load_ready4}, 32'h0);
    rst_n = 1'b1; #1;
    chk("ready_on_release", {30'b0, load_ready8, load_ready4}, 32'h3);

    for (int i = 0; i < 6; i++) send8(vecs[i].word, vecs[i].exp_par);

    // load_valid held high while data_in changes mid-frame.
    data_in8 = 8'h3C; load_valid8 = 1'b1;
    push(8, 8'h3C, 1'b0);
    push(8, 8'hC3, 1'b0);
    @(posedge clk); #1;
    data_in8 = 8'hC3;
    frame_shape(8);
    @(posedge clk); #1;
    load_valid8 = 1'b0;
    frame_shape(8);

    // Reset aborts a frame after three bits.
    data_in8 = 8'hF0; load_valid8 = 1'b1;
    push(8, 8'hF0, 1'b0);
    @(posedge clk); #1;
    load_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    #1; rst_n = 1'b0; q8.delete();
    @(negedge clk);
    chk("abort_outs", {28'b0, data_out8, bit_valid8, last_bit8, load_ready8}, 32'h0);
    rst_n = 1'b1;
    #1;
    send8(8'h81, 1'b0);

    // Reset coinciding with a load request: the word must not be captured.
    @(negedge clk);
    rst_n = 1'b0; data_in8 = 8'hFF; load_valid8 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; load_valid8 = 1'b0;
    @(negedge clk);
    chk("rst_wins", {30'b0, bit_valid8, load_ready8}, 32'h1);

    send4(4'b1001, 1'b0);
    send4(4'b0110, 1'b0);

    chk("q8_drained", q8.size(), 32'h0);
    chk("q4_drained", q4.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_piso_serial_tx.md
Name: param_piso_serial_tx

Overview:
Parameterised parallel-in/serial-out transmitter. It sits directly upstream of the shift-left serial-input register and drives that register's serial data_in.
- Accepts a width-bit word through a valid/ready handshake.
- Shifts the word out MSB first, one bit per clk, so the downstream shift-left register holds the original word after width bits.
- Flags valid and last bits so the consumer knows when its parallel output is complete.

Parameters:
width, 8, word length in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  reset; synchronous, active-low.
data_in  input  width  parallel word; sampled only on a load handshake.
load_valid  input  1  producer has a word on data_in.
load_ready  output  1  block can accept a word.
data_out  output  1  serial bit to the downstream register's data_in.
bit_valid  output  1  data_out carries a frame bit this cycle.
last_bit  output  1  high only on the final bit cycle of a frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n and is sampled only at posedge clk.
- State encoding: IDLE, SHIFT, PAR. PAR exists only with PARITY_EN.
- Internal registers: shift register sreg[width-1:0]; bit counter cnt of $clog2(width) bits; parity flop.
- Reset (rst_n=0 at posedge):
  - state=IDLE; sreg, cnt and parity flop cleared.
  - Outputs: data_out=0, bit_valid=0, last_bit=0.
  - load_ready=0 while rst_n=0.
  - Reset mid-frame aborts the frame immediately; no partial bits after the reset edge.
- Outputs:
  - load_ready = (state==IDLE) && rst_n. This is the only combinational output.
  - data_out, bit_valid and last_bit come straight from flops or state; no combinational path from any input.
- IDLE:
  - data_out=0, bit_valid=0, last_bit=0.
  - A handshake (load_valid && load_ready at posedge) captures sreg<=data_in, sets cnt<=width-1, and moves to SHIFT.
  - load_valid without ready is ignored.
- SHIFT:
  - data_out=sreg[width-1]; bit_valid=1.
  - Each posedge: sreg<=sreg<<1 with zero fill; cnt<=cnt-1.
  - last_bit=1 when cnt==0 and PARITY_EN is undefined.
  - When cnt==0 at posedge: go to PAR if PARITY_EN is defined, else to IDLE.
- Timing:
  - Handshake at edge k: the first bit is valid between edges k and k+1. Bit i (MSB=0) is valid between edges k+i and k+i+1.
  - No frame gaps within a frame. Frames are at least one IDLE cycle apart; there is no back-to-back loading.
- Inputs are don't-care outside the handshake edge. Changing data_in or load_valid mid-frame has no effect.
- Simultaneous rst_n=0 and handshake: reset wins and the word is not captured.
- Downstream contract: the consumer shifts on every bit_valid cycle. Its parallel word equals the sent word on the cycle after last_bit, or after the data bit preceding parity when PARITY_EN is defined.

Optional Feature:
Macro: PARAM_PISO_PARITY_EN.
- Defined:
  - At the handshake, the parity flop <= ^data_in (even parity).
  - After the last data bit, the state goes to PAR for one cycle: data_out=parity, bit_valid=1, last_bit=1, then IDLE.
  - Frame length is width+1. last_bit is 0 on the final data bit.
- Undefined:
  - No parity flop and no PAR state.
  - Frame length is width; last_bit is high on the final data bit.

Test Plan:
1. Reset: rst_n=0 for 2 cycles -> data_out=0, bit_valid=0, last_bit=0, load_ready=0. Release -> load_ready=1 on the same cycle.
2. Load 8'hA5 -> data_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles, last_bit high on the 8th only. Downstream shift-left register reads 8'hA5 the next cycle. load_ready=0 throughout, 1 afterwards.
3. load_valid held high, data_in=8'h3C, then changed to 8'hC3 mid-frame -> first frame sends exactly 3C. C3 is accepted only on the next load_ready edge, one idle cycle later, and is sent intact.
4. Reset asserted after 3 bits of 8'hF0 -> bit_valid=0 and data_out=0 after the reset edge. After release, load 8'h81 -> sequence 1,0,0,0,0,0,0,1, with no residue from F0.
5. PARAM_PISO_PARITY_EN defined: 8'hA5 -> 9-cycle frame, 9th bit 0 with last_bit. 8'h07 -> 9th bit 1. last_bit=0 on the 8th cycle in both cases.
6. width=4 instance: load 4'b1001 -> 1,0,0,1 over 4 cycles, last_bit on the 4th. cnt wraps correctly, and the next load 4'b0110 is accepted after one idle cycle.
